// File: rtl/fsm_pkg.sv
// Shared types for the serial pulse-train transmitter and related FSM blocks.
package fsm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } pulse_gen_state_t;

    localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/fsm_down_counter.sv
// Loadable saturating down-counter; stops at zero instead of wrapping.
module fsm_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         async_rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         is_one
);

    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en && count != '0)
            count <= count - 1'b1;
    end

    assign is_one = (count == W'(1));

endmodule

// File: rtl/fsm_pulse_gen.sv
// Serial pulse-train transmitter: burst_cnt bursts of burst_len high cycles
// separated by gap_len low cycles, with start/abort control and done/err status.
module fsm_pulse_gen
    import fsm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             async_rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] burst_len,
    input  logic [CNT_W-1:0] gap_len,
    input  logic [CNT_W-1:0] burst_cnt,
    output logic             out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    pulse_gen_state_t state, next_state;

    logic [CNT_W-1:0] burst_len_q, gap_len_q;
    logic [CNT_W-1:0] ph_count, bc_count, ph_val;
    logic             ph_is_one, bc_is_one;
    logic             ph_load, ph_en, bc_load, bc_en;
    logic             start_ok, illegal, accept, err_d;
    logic             ph_last, bc_last;

    assign start_ok = (state == IDLE || state == DONE) && start && !abort;
    assign illegal  = (burst_len == '0) || (burst_cnt == '0);
    assign accept   = start_ok && !illegal;
    assign err_d    = start_ok && illegal;

    // A zero count is treated as "last" too, so a corrupted counter can never stall the FSM.
    assign ph_last = ph_is_one || (ph_count == '0);
    assign bc_last = bc_is_one || (bc_count == '0);

    fsm_down_counter #(.W(CNT_W)) u_phase (
        .clk      (clk),
        .async_rst(async_rst),
        .load     (ph_load),
        .load_val (ph_val),
        .en       (ph_en),
        .count    (ph_count),
        .is_one   (ph_is_one)
    );

    fsm_down_counter #(.W(CNT_W)) u_bursts (
        .clk      (clk),
        .async_rst(async_rst),
        .load     (bc_load),
        .load_val (burst_cnt),
        .en       (bc_en),
        .count    (bc_count),
        .is_one   (bc_is_one)
    );

    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            state       <= IDLE;
            burst_len_q <= '0;
            gap_len_q   <= '0;
            out         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                burst_len_q <= burst_len;
                gap_len_q   <= gap_len;
            end
            out  <= (next_state == BURST);
            busy <= (next_state == BURST) || (next_state == GAP);
            done <= (next_state == DONE) || err_d;
            err  <= err_d;
        end
    end

    always_comb begin
        next_state = state;
        ph_load    = 1'b0;
        ph_val     = burst_len_q;
        ph_en      = 1'b0;
        bc_load    = 1'b0;
        bc_en      = 1'b0;
        case (state)
            IDLE, DONE: begin
                next_state = IDLE;
                if (accept) begin
                    next_state = BURST;
                    ph_load    = 1'b1;
                    ph_val     = burst_len;
                    bc_load    = 1'b1;
                end
            end
            BURST: begin
                ph_en = 1'b1;
                if (abort) begin
                    next_state = IDLE;
                end else if (ph_last) begin
                    bc_en = 1'b1;
                    if (bc_last) begin
                        next_state = DONE;
                    end else if (gap_len_q != '0) begin
                        next_state = GAP;
                        ph_load    = 1'b1;
                        ph_val     = gap_len_q;
                    end else begin
                        // zero gap: bursts merge into one continuous high stretch
                        ph_load = 1'b1;
                    end
                end
            end
            GAP: begin
                ph_en = 1'b1;
                if (abort) begin
                    next_state = IDLE;
                end else if (ph_last) begin
                    next_state = BURST;
                    ph_load    = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fsm_pulse_gen.sv
// Directed bench for fsm_pulse_gen: vector table plus hand-written corner sequences.
module tb_fsm_pulse_gen;

    logic       clk = 1'b0;
    logic       async_rst;
    logic       start, abort;
    logic [7:0] burst_len, gap_len, burst_cnt;
    logic       out, busy, done, err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       start;
        logic       abort;
        logic [7:0] bl;
        logic [7:0] gl;
        logic [7:0] bc;
        logic [3:0] exp;   // {out, busy, done, err} in the following cycle
    } vec_t;

    vec_t vecs[$];

    fsm_pulse_gen #(.CNT_W(8)) dut (
        .clk      (clk),
        .async_rst(async_rst),
        .start    (start),
        .abort    (abort),
        .burst_len(burst_len),
        .gap_len  (gap_len),
        .burst_cnt(burst_cnt),
        .out      (out),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic add(input logic s, input logic a, input logic [7:0] bl, input logic [7:0] gl,
                       input logic [7:0] bc, input logic [3:0] exp);
        vec_t v;
        v.start = s; v.abort = a; v.bl = bl; v.gl = gl; v.bc = bc; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic s, input logic a, input logic [7:0] bl, input logic [7:0] gl,
                         input logic [7:0] bc);
        start = s; abort = a; burst_len = bl; gap_len = gl; burst_cnt = bc;
    endtask

    initial begin
        int highs;

        // normal train 3/2/2
        add(1, 0, 3, 2, 2, 4'b1100);
        add(0, 0, 3, 2, 2, 4'b1100);
        add(0, 0, 3, 2, 2, 4'b1100);
        add(0, 0, 3, 2, 2, 4'b0100);
        add(0, 0, 3, 2, 2, 4'b0100);
        add(0, 0, 3, 2, 2, 4'b1100);
        add(0, 0, 3, 2, 2, 4'b1100);
        add(0, 0, 3, 2, 2, 4'b1100);
        add(0, 0, 3, 2, 2, 4'b0010);
        add(0, 0, 3, 2, 2, 4'b0000);
        // merged bursts 2/0/3
        add(1, 0, 2, 0, 3, 4'b1100);
        for (int i = 0; i < 5; i++) add(0, 0, 2, 0, 3, 4'b1100);
        add(0, 0, 2, 0, 3, 4'b0010);
        add(0, 0, 2, 0, 3, 4'b0000);
        // illegal configs
        add(1, 0, 0, 3, 5, 4'b0011);
        add(0, 0, 0, 3, 5, 4'b0000);
        add(0, 0, 0, 3, 5, 4'b0000);
        add(1, 0, 4, 1, 0, 4'b0011);
        add(0, 0, 4, 1, 0, 4'b0000);

        drive(0, 0, 0, 0, 0);
        async_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", {out, busy, done, err}, 4'b0000);
        @(negedge clk) async_rst = 1'b1;
        step();

        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].abort, vecs[i].bl, vecs[i].gl, vecs[i].bc);
            step();
            chk($sformatf("vec%0d", i), {out, busy, done, err}, vecs[i].exp);
        end

        // reset mid-train
        drive(1, 0, 4, 2, 3);
        step();
        start = 1'b0;
        chk("rst_pre", {out, busy}, 2'b11);
        repeat (4) step();
        #2 async_rst = 1'b0;
        #1 chk("rst_async", {out, busy, done}, 3'b000);
        @(negedge clk) async_rst = 1'b1;
        step();
        drive(1, 0, 1, 0, 1);
        step();
        start = 1'b0;
        chk("rst_restart", {out, busy, done}, 3'b110);
        step();
        chk("rst_done", {out, busy, done}, 3'b001);
        step();

        // abort and ignored start
        drive(1, 0, 5, 1, 2);
        step();
        start = 1'b0;
        chk("ab_c1", {out, busy}, 2'b11);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b1;
        chk("ab_c3", {out, busy, done}, 3'b110);
        step();
        abort = 1'b0;
        chk("ab_c4", {out, busy, done, err}, 4'b0000);
        step();
        chk("ab_c5", {out, busy, done, err}, 4'b0000);
        start = 1'b1;
        abort = 1'b1;
        step();
        chk("ab_blocked", {out, busy, done, err}, 4'b0000);
        start = 1'b0;
        abort = 1'b0;
        step();
        chk("ab_blocked2", {out, busy}, 2'b00);

        // back-to-back with start held through DONE
        drive(1, 0, 1, 0, 1);
        step();
        chk("b2b_c1", {out, busy, done}, 3'b110);
        step();
        chk("b2b_c2", {out, busy, done}, 3'b001);
        step();
        chk("b2b_c3", {out, busy, done}, 3'b110);
        start = 1'b0;
        step();
        chk("b2b_c4", {out, busy, done}, 3'b001);
        step();
        chk("b2b_c5", {out, busy, done}, 3'b000);

        // maximum burst length
        drive(1, 0, 8'd255, 0, 1);
        highs = 0;
        for (int i = 0; i < 255; i++) begin
            step();
            start = 1'b0;
            if (out) highs++;
        end
        chk("max_highs", highs, 255);
        step();
        chk("max_done", {out, busy, done}, 3'b001);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fsm_pulse_gen.md
Name: fsm_pulse_gen

Overview:
Serial pulse-train transmitter: on a start request it drives `out` high for a programmable number of cycles, low for a programmable gap, and repeats for a programmable burst count. It then signals completion.
It is the producing end of the single-bit serial pulse line that the team's FSM sequence detectors consume. It is used as the stimulus source in-system and in benches.
The control side is a one-cycle start strobe with busy/done status, plus an abort.

Parameters:
CNT_W, 8, width of burst_len, gap_len and burst_cnt (legal range 2..16).

Ports:
clk  input  1  rising-edge clock
async_rst  input  1  asynchronous active-low reset
start  input  1  request strobe; sampled every cycle, accepted only when busy==0
abort  input  1  cancel the train in progress
burst_len  input  CNT_W  high cycles per burst; latched on accept
gap_len  input  CNT_W  low cycles between bursts; latched on accept
burst_cnt  input  CNT_W  number of bursts; latched on accept
out  output  1  serial pulse line, registered
busy  output  1  high while a train is in progress
done  output  1  one-cycle pulse when a train completes normally
err  output  1  one-cycle pulse when start is accepted with illegal config

Behaviour:
- Reset (async_rst==0, asynchronous assert, synchronous deassert by clk):
  - state=IDLE
  - out=0, busy=0, done=0, err=0
  - all counters and latched config cleared.
- All outputs are registered, with no combinational input-to-output path.
- States (enum): IDLE, BURST, GAP, DONE.
- IDLE:
  - out=0, busy=0.
  - On start && !abort with burst_len!=0 and burst_cnt!=0: latch the config, load the phase counter with burst_len and the burst counter with burst_cnt, and go to BURST.
  - On start with burst_len==0 or burst_cnt==0: stay IDLE, pulse err=1 and done=1 together in the next cycle, never raise out.
- Latency: start accepted at edge t, so out=1 and busy=1 from cycle t+1.
- BURST:
  - out=1 and busy=1 for exactly burst_len cycles. The phase counter decrements each cycle.
  - At the last high cycle, burst counter decrements. If bursts remain and gap_len!=0, go to GAP (load gap_len). If bursts remain and gap_len==0, reload burst_len and stay in BURST, so out stays 1 and bursts merge. If no bursts remain, go to DONE.
- GAP:
  - out=0, busy=1 for exactly gap_len cycles, then reload burst_len and go to BURST.
  - There is no trailing gap after the final burst.
- DONE: one cycle with out=0, busy=0, done=1, then IDLE.
- Start in DONE: it is accepted (busy==0), and the new train begins next cycle with the same latency as from IDLE.
- Start while busy==1: ignored and not queued. Config inputs are don't-care while busy.
- Abort:
  - In BURST or GAP: next cycle state=IDLE, out=0, busy=0, with no done and no err.
  - Abort in IDLE or DONE: no effect, except that abort together with start blocks acceptance (abort wins).
- Total high cycles for a normal train = burst_len*burst_cnt. Total train length (busy cycles) = burst_len*burst_cnt + gap_len*(burst_cnt-1).
- Counters are CNT_W bits and load the full value, so burst_len = 2^CNT_W-1 is legal. Down-counters never wrap: the zero check is taken before decrement.
- Reset asserted mid-train: immediate return to reset values, out drops asynchronously.

Decomposition:
- Shared package fsm_pkg holds:
  - state enum pulse_gen_state_t (2-bit: IDLE=0, BURST=1, GAP=2, DONE=3)
  - localparam default CNT_W.
- One sub-module, fsm_down_counter (parameter W): load, load_val, en, count output, and a registered-free is_one flag.
  - Instantiated twice: once as the phase counter, once as the burst counter.

Test Plan:
1. Reset mid-train: burst_len=4, gap_len=2, burst_cnt=3, start at cycle 0, async_rst low at cycle 5 -> out, busy, done go 0 immediately. After release, start is accepted normally.
2. Normal train: burst_len=3, gap_len=2, burst_cnt=2, start at cycle 0. Required:
   - out=1 at cycles 1-3, 0 at cycles 4-5, 1 at cycles 6-8
   - busy=1 at cycles 1-8
   - done=1 at cycle 9 only
   - err never asserts.
3. Merged bursts: burst_len=2, gap_len=0, burst_cnt=3 -> out=1 for 6 consecutive cycles (1-6), done at cycle 7.
4. Illegal config: burst_len=0, burst_cnt=5, start -> out stays 0, busy stays 0, err=1 and done=1 for one cycle only.
5. Abort/ignore: during a burst_len=5, burst_cnt=2 train:
   - pulse start at cycle 2 -> ignored
   - abort at cycle 3 -> out=0, busy=0 from cycle 4, no done.
   - Then start with abort also high -> not accepted.
6. Back-to-back: start held high through the DONE cycle of a burst_len=1, burst_cnt=1 train -> second train's out=1 in the cycle after done, and done pulses once per train.
